// File: rtl/sub2_sched_pkg.sv
// Shared types and constants for the sub2 scheduler.
// The optional WAIT timeout is enabled by the SUB2_SCHED_TIMEOUT_EN macro.
package sub2_sched_pkg;
  localparam int LANES = 3;
  localparam int DW    = 8;

  typedef logic [0:LANES-1][DW-1:0] lane_vec_t;
  typedef logic [1:0] mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] STAT_TIMEOUT = 2'b11;
endpackage

// File: rtl/sub2_rr_arb.sv
// Round-robin priority picker: searches upward from ptr_i+1 with wrap and
// returns a one-hot grant plus the winning index.
module sub2_rr_arb #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (int'(ptr_i) + i) % N;
      if (!any_o && req_i[c]) begin
        gnt_o[c] = 1'b1;
        idx_o    = c[IW-1:0];
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sub2_sched.sv
// Shares one sub2 datapath between NUM_REQ requesters, one operation in flight.
// Define SUB2_SCHED_TIMEOUT_EN to abandon a WAIT after TIMEOUT_CYC cycles.
//
// state | meaning
// IDLE  | arbitrate; accept one request
// ISSUE | pulse sub2 start
// WAIT  | wait for sub2 done
// RESP  | hold response until i_rsp_rdy
module sub2_sched #(
  parameter int NUM_REQ     = 4,
  parameter int LANES       = sub2_sched_pkg::LANES,
  parameter int DW          = sub2_sched_pkg::DW,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NUM_REQ-1:0]                  i_req_vld,
  output logic [NUM_REQ-1:0]                  o_req_rdy,
  input  logic [NUM_REQ-1:0][1:0]             i_req_mode,
  input  logic [NUM_REQ-1:0][0:LANES-1][DW-1:0] i_req_data,
  output logic                                o_dp_sig_e,
  output logic [1:0]                          o_dp_sig_f,
  output logic [0:LANES-1][DW-1:0]            o_dp_sig_g,
  output logic [DW-1:0]                       o_dp_sig_h [0:LANES-1],
  input  logic                                i_dp_sig_i,
  input  logic [1:0]                          i_dp_sig_j,
  input  logic [0:LANES-1][DW-1:0]            i_dp_sig_k,
  input  logic [DW-1:0]                       i_dp_sig_l [0:LANES-1],
  output logic                                o_rsp_vld,
  input  logic                                i_rsp_rdy,
  output logic [$clog2(NUM_REQ)-1:0]          o_rsp_id,
  output logic [1:0]                          o_rsp_stat,
  output logic [0:LANES-1][DW-1:0]            o_rsp_data
);
  import sub2_sched_pkg::*;

  localparam int IW = $clog2(NUM_REQ);

  state_t                    state_q, state_d;
  logic [IW-1:0]             ptr_q, ptr_d;
  logic [IW-1:0]             id_q, id_d;
  mode_t                     mode_q, mode_d;
  logic [0:LANES-1][DW-1:0]  op_q, op_d;
  logic [1:0]                stat_q, stat_d;
  logic [0:LANES-1][DW-1:0]  rdata_q, rdata_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;

`ifdef SUB2_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_q, tmo_d;
`endif

  sub2_rr_arb #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req_i (i_req_vld),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    mode_d  = mode_q;
    op_d    = op_q;
    stat_d  = stat_q;
    rdata_d = rdata_q;
`ifdef SUB2_SCHED_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          id_d    = arb_idx;
          mode_d  = i_req_mode[arb_idx];
          op_d    = i_req_data[arb_idx];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef SUB2_SCHED_TIMEOUT_EN
        tmo_d   = CW'(TIMEOUT_CYC - 1);
`endif
      end
      WAIT: begin
        if (i_dp_sig_i) begin
          stat_d  = i_dp_sig_j;
          rdata_d = i_dp_sig_k;
          state_d = RESP;
        end
`ifdef SUB2_SCHED_TIMEOUT_EN
        else if (tmo_q == '0) begin
          stat_d  = STAT_TIMEOUT;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
`endif
      end
      RESP: begin
        // operand outputs return to zero whenever the block is idle
        if (i_rsp_rdy) begin
          ptr_d   = id_q;
          mode_d  = '0;
          op_d    = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NUM_REQ - 1);
      id_q    <= '0;
      mode_q  <= '0;
      op_q    <= '0;
      stat_q  <= '0;
      rdata_q <= '0;
`ifdef SUB2_SCHED_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      mode_q  <= mode_d;
      op_q    <= op_d;
      stat_q  <= stat_d;
      rdata_q <= rdata_d;
`ifdef SUB2_SCHED_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign o_req_rdy  = (state_q == IDLE) ? arb_gnt : '0;
  assign o_dp_sig_e = (state_q == ISSUE);
  assign o_dp_sig_f = mode_q;
  assign o_dp_sig_g = op_q;
  assign o_rsp_vld  = (state_q == RESP);
  assign o_rsp_id   = id_q;
  assign o_rsp_stat = stat_q;
  assign o_rsp_data = rdata_q;

  always_comb begin
    for (int n = 0; n < LANES; n++) o_dp_sig_h[n] = op_q[n];
  end

  // the unpacked result mirrors the packed one and is deliberately not used
  logic unused_l;
  always_comb begin
    unused_l = 1'b0;
    for (int n = 0; n < LANES; n++) unused_l = unused_l ^ (^i_dp_sig_l[n]);
  end

endmodule

// File: tb/tb_sub2_sched.sv
// Directed, table-driven bench for sub2_sched (NUM_REQ=4, TIMEOUT_CYC=8).
module tb_sub2_sched;
  localparam int NR = 4;
  localparam int LN = 3;

  logic                   i_clk, i_rst;
  logic [NR-1:0]          i_req_vld, o_req_rdy;
  logic [NR-1:0][1:0]     i_req_mode;
  logic [NR-1:0][0:LN-1][7:0] i_req_data;
  logic                   o_dp_sig_e;
  logic [1:0]             o_dp_sig_f;
  logic [0:LN-1][7:0]     o_dp_sig_g;
  logic [7:0]             o_dp_sig_h [0:LN-1];
  logic                   i_dp_sig_i;
  logic [1:0]             i_dp_sig_j;
  logic [0:LN-1][7:0]     i_dp_sig_k;
  logic [7:0]             i_dp_sig_l [0:LN-1];
  logic                   o_rsp_vld, i_rsp_rdy;
  logic [1:0]             o_rsp_id, o_rsp_stat;
  logic [0:LN-1][7:0]     o_rsp_data;

  int total = 0;
  int bad   = 0;

  sub2_sched #(.NUM_REQ(NR), .LANES(LN), .DW(8), .TIMEOUT_CYC(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy),
    .i_req_mode(i_req_mode), .i_req_data(i_req_data),
    .o_dp_sig_e(o_dp_sig_e), .o_dp_sig_f(o_dp_sig_f),
    .o_dp_sig_g(o_dp_sig_g), .o_dp_sig_h(o_dp_sig_h),
    .i_dp_sig_i(i_dp_sig_i), .i_dp_sig_j(i_dp_sig_j),
    .i_dp_sig_k(i_dp_sig_k), .i_dp_sig_l(i_dp_sig_l),
    .o_rsp_vld(o_rsp_vld), .i_rsp_rdy(i_rsp_rdy),
    .o_rsp_id(o_rsp_id), .o_rsp_stat(o_rsp_stat), .o_rsp_data(o_rsp_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (i_dp_sig_i) begin
      for (int n = 0; n < LN; n++)
        assert (i_dp_sig_l[n] == i_dp_sig_k[n]) else $error("l/k lane %0d differ", n);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0]  vld;
    int          id;
    logic [1:0]  j;
    logic [23:0] k;
    int          dly;
    int          bp;
    bit          early;
  } vec_t;

  vec_t vecs[6];

  task automatic tick;
    @(posedge i_clk);
    #2;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic set_done(input bit d, input logic [1:0] j, input logic [23:0] k);
    i_dp_sig_i = d;
    i_dp_sig_j = j;
    i_dp_sig_k = k;
    for (int n = 0; n < LN; n++) i_dp_sig_l[n] = i_dp_sig_k[n];
  endtask

  task automatic do_reset;
    i_rst = 1'b1;
    tick;
    tick;
    i_rst = 1'b0;
    tick;
  endtask

  // one full operation starting in IDLE; vld is held for the whole operation
  task automatic do_op(input logic [3:0] vld, input int id, input logic [1:0] j,
                       input logic [23:0] k, input int dly, input int bp, input bit early);
    i_req_vld = vld;
    #1;
    check("rdy_grant", 32'(o_req_rdy), 32'(1 << id));
    tick;
    check("rdy_issue", 32'(o_req_rdy), 0);
    check("e_issue", 32'(o_dp_sig_e), 1);
    check("f_mode", 32'(o_dp_sig_f), 32'(i_req_mode[id]));
    check("g_data", 32'(o_dp_sig_g), 32'(i_req_data[id]));
    for (int n = 0; n < LN; n++) check("h_lane", 32'(o_dp_sig_h[n]), 32'(i_req_data[id][n]));
    if (early) set_done(1'b1, ~j, 24'h5A5A5A);
    tick;
    set_done(1'b0, 2'b00, 24'h0);
    for (int w = 0; w < dly; w++) begin
      check("e_wait", 32'(o_dp_sig_e), 0);
      check("vld_wait", 32'(o_rsp_vld), 0);
      tick;
    end
    set_done(1'b1, j, k);
    check("g_hold", 32'(o_dp_sig_g), 32'(i_req_data[id]));
    check("rdy_wait", 32'(o_req_rdy), 0);
    tick;
    set_done(1'b0, 2'b00, 24'h0);
    check("rsp_vld", 32'(o_rsp_vld), 1);
    check("rsp_id", 32'(o_rsp_id), 32'(id));
    check("rsp_stat", 32'(o_rsp_stat), 32'(j));
    check("rsp_data", 32'(o_rsp_data), 32'(k));
    check("f_resp", 32'(o_dp_sig_f), 32'(i_req_mode[id]));
    for (int b = 0; b < bp; b++) begin
      tick;
      #1;
      check("bp_vld", 32'(o_rsp_vld), 1);
      check("bp_id", 32'(o_rsp_id), 32'(id));
      check("bp_data", 32'(o_rsp_data), 32'(k));
      check("bp_rdy", 32'(o_req_rdy), 0);
    end
    i_rsp_rdy = 1'b1;
    tick;
    i_rsp_rdy = 1'b0;
    check("rsp_drop", 32'(o_rsp_vld), 0);
    check("f_idle", 32'(o_dp_sig_f), 0);
    check("g_idle", 32'(o_dp_sig_g), 0);
  endtask

  initial begin
    int w;
    i_rst = 1'b1;
    i_req_vld = '0;
    i_rsp_rdy = 1'b0;
    set_done(1'b0, 2'b00, 24'h0);
    i_req_mode[0] = 2'b00; i_req_data[0] = 24'h010203;
    i_req_mode[1] = 2'b10; i_req_data[1] = 24'h112233;
    i_req_mode[2] = 2'b01; i_req_data[2] = 24'h445566;
    i_req_mode[3] = 2'b11; i_req_data[3] = 24'h778899;

    vecs[0] = '{4'b0010, 1, 2'b01, 24'hA0A1A2, 0, 0, 1'b0};
    vecs[1] = '{4'b1011, 3, 2'b10, 24'hB0B1B2, 2, 5, 1'b0};
    vecs[2] = '{4'b1010, 1, 2'b00, 24'hC0C1C2, 1, 0, 1'b1};
    vecs[3] = '{4'b0101, 2, 2'b11, 24'hD0D1D2, 0, 1, 1'b0};
    vecs[4] = '{4'b1000, 3, 2'b01, 24'hE0E1E2, 3, 0, 1'b0};
    vecs[5] = '{4'b0001, 0, 2'b10, 24'hF0F1F2, 0, 2, 1'b0};

    tick;
    tick;
    check("rst_rsp_vld", 32'(o_rsp_vld), 0);
    check("rst_e", 32'(o_dp_sig_e), 0);
    check("rst_f", 32'(o_dp_sig_f), 0);
    check("rst_g", 32'(o_dp_sig_g), 0);
    check("rst_h0", 32'(o_dp_sig_h[0]), 0);
    check("rst_rdy", 32'(o_req_rdy), 0);
    check("rst_stat", 32'(o_rsp_stat), 0);
    check("rst_data", 32'(o_rsp_data), 0);
    i_rst = 1'b0;
    tick;
    check("idle_no_req", 32'(o_req_rdy), 0);

    for (int v = 0; v < 6; v++)
      do_op(vecs[v].vld, vecs[v].id, vecs[v].j, vecs[v].k, vecs[v].dly, vecs[v].bp, vecs[v].early);

    // round robin with every requester asserted
    i_req_vld = '0;
    do_reset;
    for (int r = 0; r < 5; r++)
      do_op(4'b1111, r % 4, 2'(r), 24'h300000 + 24'(r), 0, 0, 1'b0);

    // reset while waiting for done abandons the operation
    i_req_vld = 4'b0100;
    #1;
    check("rdy_pre_rst", 32'(o_req_rdy), 32'b0100);
    tick;
    tick;
    i_req_vld = '0;
    check("f_in_wait", 32'(o_dp_sig_f), 32'(i_req_mode[2]));
    #1;
    i_rst = 1'b1;
    #1;
    check("arst_f", 32'(o_dp_sig_f), 0);
    check("arst_g", 32'(o_dp_sig_g), 0);
    check("arst_h2", 32'(o_dp_sig_h[2]), 0);
    check("arst_vld", 32'(o_rsp_vld), 0);
    tick;
    tick;
    i_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      check("no_stale_rsp", 32'(o_rsp_vld), 0);
    end
    do_op(4'b1111, 0, 2'b01, 24'h123456, 0, 0, 1'b0);

    // missing done
    i_req_vld = 4'b0010;
    #1;
    check("rdy_tmo", 32'(o_req_rdy), 32'b0010);
    tick;
    tick;
    i_req_vld = '0;
`ifdef SUB2_SCHED_TIMEOUT_EN
    w = 0;
    while (!o_rsp_vld && w < 20) begin
      tick;
      w++;
    end
    check("tmo_cycles", 32'(w), 8);
    check("tmo_stat", 32'(o_rsp_stat), 32'b11);
    check("tmo_data", 32'(o_rsp_data), 0);
    check("tmo_id", 32'(o_rsp_id), 1);
    i_rsp_rdy = 1'b1;
    tick;
    i_rsp_rdy = 1'b0;
    set_done(1'b1, 2'b01, 24'hABCDEF);
    tick;
    set_done(1'b0, 2'b00, 24'h0);
    tick;
    check("late_done", 32'(o_rsp_vld), 0);
`else
    w = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (o_rsp_vld) w++;
    end
    check("no_tmo_rsp", 32'(w), 0);
    check("still_wait_f", 32'(o_dp_sig_f), 32'(i_req_mode[1]));
    do_reset;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sub2_sched.md
Name: sub2_sched

Overview:
- Shares one sub2 datapath instance between NUM_REQ requesters.
- Round-robin arbiter plus a sequencing FSM:
  - accepts one request;
  - drives sub2 inputs (e/f/g/h) and pulses start;
  - waits for sub2 done;
  - captures the result (j/k/l) and returns it with the requester ID over a valid/ready response port.
- Sits between requester blocks and sub2; exactly one operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- LANES, 3, byte lanes per operand/result (matches sub2 [0:2])
- DW, 8, lane width in bits
- TIMEOUT_CYC, 64, WAIT-state limit in cycles; used only with SUB2_SCHED_TIMEOUT_EN

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_req_vld  in  NUM_REQ  per-requester request valid
- o_req_rdy  out  NUM_REQ  per-requester accept; one-hot or zero
- i_req_mode  in  [NUM_REQ-1:0][1:0]  per-requester mode
- i_req_data  in  [NUM_REQ-1:0][0:LANES-1][DW-1:0]  per-requester operand
- o_dp_sig_e  out  1  sub2 start pulse
- o_dp_sig_f  out  2  sub2 mode
- o_dp_sig_g  out  [0:LANES-1][DW-1:0]  sub2 packed operand
- o_dp_sig_h  out  [DW-1:0] x [0:LANES-1] unpacked  same operand, unpacked copy
- i_dp_sig_i  in  1  sub2 done
- i_dp_sig_j  in  2  sub2 status
- i_dp_sig_k  in  [0:LANES-1][DW-1:0]  sub2 packed result
- i_dp_sig_l  in  [DW-1:0] x [0:LANES-1] unpacked  sub2 unpacked result (not returned; see Behaviour)
- o_rsp_vld  out  1  response valid
- i_rsp_rdy  in  1  response ready
- o_rsp_id  out  $clog2(NUM_REQ)  granted requester index
- o_rsp_stat  out  2  status (i_dp_sig_j, or 2'b11 on timeout)
- o_rsp_data  out  [0:LANES-1][DW-1:0]  result

Behaviour:
- Reset (i_rst high, asynchronous):
  - state=IDLE; rr pointer=NUM_REQ-1, so requester 0 wins first;
  - all outputs 0; latched operand/result registers 0.
  - Reset mid-operation abandons the operation; no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first asserted i_req_vld searching from ptr+1 upward, with wrap.
  - o_req_rdy[winner]=1 combinationally, only in IDLE.
  - Handshake (vld&rdy) latches id, mode and data, then goes to ISSUE.
  - No valid requests: remain in IDLE, o_req_rdy=0.
- ISSUE (1 cycle): o_dp_sig_e=1; go to WAIT.
- o_dp_sig_f/g/h are registered from the latched values. They are valid from ISSUE through RESP, hold stable, and return to 0 in IDLE.
- o_dp_sig_h[n] equals o_dp_sig_g[n] for every lane n.
- WAIT:
  - i_dp_sig_i sampled high: capture i_dp_sig_j into stat and i_dp_sig_k into data; go to RESP.
  - i_dp_sig_l is ignored; in a bench assertion it must equal i_dp_sig_k lane-wise at the done cycle.
  - i_dp_sig_i high during ISSUE is ignored.
- RESP:
  - o_rsp_vld=1 with id/stat/data stable until i_rsp_rdy.
  - On handshake: ptr<=id, go to IDLE, o_rsp_vld drops the next cycle.
- Latency:
  - accept at cycle 0; e pulse at cycle 1; earliest done sampled at cycle 2; o_rsp_vld at cycle 3.
  - Earliest next accept is the cycle after the response handshake.
- Fairness: a requester holding vld is granted within NUM_REQ operations.
- A requester dropping vld before grant is legal. The arbiter never grants a non-asserted vld.

Optional Feature:
- Macro: SUB2_SCHED_TIMEOUT_EN.
- Defined:
  - A WAIT counter clears on entering WAIT.
  - If i_dp_sig_i is still not seen after TIMEOUT_CYC cycles in WAIT, go to RESP with stat=2'b11 and data=0.
  - A late done then arriving in RESP/IDLE is ignored.
- Undefined: no counter; WAIT waits indefinitely; stat is always i_dp_sig_j.

Decomposition:
- Package sub2_sched_pkg:
  - LANES and DW constants;
  - typedef lane_vec_t (logic [0:LANES-1][DW-1:0]);
  - typedef mode_t (logic [1:0]);
  - enum state_t {IDLE, ISSUE, WAIT, RESP};
  - localparam STAT_TIMEOUT = 2'b11.
- Sub-module: sub2_rr_arb, a parameterised round-robin priority picker with pointer input, giving a one-hot grant and an index. The FSM stays in sub2_sched.

Test Plan:
- Single request: req1 vld, mode=2'b10, data={8'h11,8'h22,8'h33}, done at cycle 2 with j=2'b01 and k={8'hA0,8'hA1,8'hA2} → e pulse at cycle 1, f/g/h match the request, rsp at cycle 3 with id=1, stat=01, data=A0A1A2.
- All 4 vld continuously → grant order 0,1,2,3,0; each response id matches; no rdy asserted outside IDLE.
- Response backpressure: i_rsp_rdy low for 5 cycles → o_rsp_vld/id/data held stable; no new o_req_rdy until the handshake.
- Reset asserted in WAIT → outputs 0 immediately (asynchronous); after release req0 is granted first; no stale rsp.
- Done asserted during ISSUE and again in WAIT → only the WAIT sample is captured; exactly one response.
- With SUB2_SCHED_TIMEOUT_EN and TIMEOUT_CYC=8, done never asserted → rsp stat=11, data=0 after 8 WAIT cycles. Without the macro → remains in WAIT, no rsp.
